// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time, with read-modify-write for sub-word stores.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses instead of truncating them.
module lsu_ctrl #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  logic        store_q;
  logic        signed_q;
  logic        err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;

  logic        misalign;
  logic        req_err;
  logic [31:0] eff_addr;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] sz, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   extract = {{24{sg & b[7]}}, b};
      2'b01:   extract = {{16{sg & h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] a,
                                        input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] mask;
    logic [4:0]  sh;
    sh   = (sz == 2'b01) ? {a[1], 4'b0000} : {a, 3'b000};
    mask = (sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    merge = (w & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  // Request classification; truncation only matters when misalignment is not trapped.
  always_comb begin
    misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((req_size == 2'b01) && req_addr[0]) ||
               ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    req_err = (req_size == 2'b11) || (req_addr >= MEM_BYTES) || misalign;
    case (req_size)
      2'b01:   eff_addr = {req_addr[31:1], 1'b0};
      2'b10:   eff_addr = {req_addr[31:2], 2'b00};
      default: eff_addr = req_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      store_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q  <= req_store;
            signed_q <= req_signed;
            size_q   <= req_size;
            addr_q   <= eff_addr;
            wdata_q  <= req_wdata;
            err_q    <= req_err;
            rdata_q  <= '0;
            if (req_err)
              state <= RESP;
            else if (req_store && (req_size == 2'b10))
              state <= WR;
            else
              state <= RD;
          end
        end
        RD: begin
          word_q <= mem_rd;
          if (!store_q)
            rdata_q <= extract(mem_rd, addr_q[1:0], size_q, signed_q);
          state <= store_q ? WR : RESP;
        end
        WR: state <= RESP;
        RESP: begin
          if (resp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Everything is forced to its idle value while reset is low so no write can slip through.
  assign req_ready  = (state == IDLE) || !reset;
  assign resp_valid = (state == RESP) && reset;
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_err   = resp_valid && err_q;
  assign mem_we     = (state == WR) && reset;
  assign mem_a      = (reset && ((state == RD) || (state == WR))) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wd     = mem_we ? ((size_q == 2'b10) ? wdata_q : merge(word_q, addr_q[1:0], size_q, wdata_q))
                             : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: random loads/stores against an array-based reference memory.
// Honours LSU_MISALIGN_TRAP_EN in its reference model.
module tb_lsu_ctrl;

  localparam int MEM_WORDS = 64;
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          riseCyc;
    int          wBase;
    int          writes;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] dmem[MEM_WORDS];
  logic [31:0] refMem[MEM_WORDS];
  logic        plEn = 1'b0;
  logic [5:0]  plIdx = '0;
  logic [31:0] plVal = '0;
  int          cyc = 0;
  int          nChecks = 0;
  int          nPass = 0;
  int          wCount = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_we(mem_we),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Data memory seen by the DUT, plus a preload port for the bench.
  always @(posedge clk) begin
    if (plEn)
      dmem[plIdx] <= plVal;
    else if (mem_we)
      dmem[mem_a[7:2]] <= mem_wd;
  end

  assign mem_rd = (mem_a < MEM_BYTES) ? dmem[mem_a[7:2]] : 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act === expv)
      nPass++;
    else
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // Reference behaviour: plain arithmetic on a word array.
  task automatic modelAccess(input logic st, input logic [1:0] sz, input logic sg,
                             input logic [31:0] ad, input logic [31:0] wd, output exp_t e);
    logic [31:0] w;
    logic [31:0] v;
    int          idx;
    int          sh;
    e.err = (sz == 2'd3) || (ad >= MEM_BYTES);
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz == 2'd1 && (ad % 2) != 0) e.err = 1'b1;
    if (sz == 2'd2 && (ad % 4) != 0) e.err = 1'b1;
`endif
    e.rdata  = 32'h0;
    e.writes = 0;
    e.riseCyc = 1;
    if (!e.err) begin
      idx = int'(ad / 4);
      w   = refMem[idx];
      if (!st) begin
        e.riseCyc = 2;
        if (sz == 2'd0) begin
          v = (w >> (8 * (ad % 4))) & 32'hFF;
          if (sg && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
          v = (w >> (16 * ((ad / 2) % 2))) & 32'hFFFF;
          if (sg && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else
          v = w;
        e.rdata = v;
      end else begin
        e.writes = 1;
        if (sz == 2'd2) begin
          e.riseCyc = 2;
          refMem[idx] = wd;
        end else begin
          e.riseCyc = 3;
          if (sz == 2'd0) begin
            sh = 8 * int'(ad % 4);
            refMem[idx] = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
          end else begin
            sh = 16 * int'((ad / 2) % 2);
            refMem[idx] = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
          end
        end
      end
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    plEn  = 1'b1;
    plIdx = 6'(idx);
    plVal = val;
    refMem[idx] = val;
    @(posedge clk); #1;
    plEn = 1'b0;
  endtask

  task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic sg,
                               input logic [31:0] ad, input logic [31:0] wd, input int stall);
    exp_t e;
    int   left;
    logic hs;
    logic done;
    left = stall;
    done = 1'b0;
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!req_ready) begin
      checkOutput("req_ready_wait", 32'(req_ready), 32'd1);
      return;
    end
    req_valid  = 1'b1;
    req_store  = st;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ad;
    req_wdata  = wd;
    resp_ready = 1'b0;
    modelAccess(st, sz, sg, ad, wd, e);
    e.riseCyc = cyc + e.riseCyc;
    e.wBase   = wCount;
    expQ.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (left > 0) begin
        resp_ready = 1'b0;
        if (resp_valid) left--;
      end else
        resp_ready = (stall > 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      hs = resp_valid && resp_ready;
      // Busy-time requests carry junk and must be ignored.
      req_valid = !hs && ($urandom_range(0, 1) == 1);
      req_store = 1'($urandom_range(0, 1));
      req_size  = 2'($urandom_range(0, 3));
      req_addr  = $urandom_range(0, 255);
      req_wdata = $urandom();
      @(posedge clk); #1;
      done = hs;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    if (!done) checkOutput("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic resetDuringWrite();
    int   base;
    logic seen;
    logic sawValid;
    seen = 1'b0;
    sawValid = 1'b0;
    preload(5, 32'h1122_3344);
    req_valid = 1'b1;
    req_store = 1'b1;
    req_size  = 2'd0;
    req_addr  = 32'h15;
    req_wdata = 32'h0000_0099;
    base = wCount;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (mem_we) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    checkOutput("rst_wr_reached", 32'(seen), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_a", mem_a, 32'h0);
    checkOutput("rst_mem_wd", mem_wd, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    resp_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) sawValid = 1'b1;
    end
    resp_ready = 1'b0;
    checkOutput("rst_no_resp", 32'(sawValid), 32'd0);
    checkOutput("rst_no_write", 32'(wCount - base), 32'd0);
    checkOutput("rst_mem_kept", dmem[5], 32'h1122_3344);
  endtask

  // Monitor: pops an expectation on every response handshake.
  initial begin
    logic        prevValid;
    int          riseCyc;
    logic [31:0] riseData;
    logic        riseErr;
    logic        stable;
    exp_t        e;
    prevValid = 1'b0;
    riseCyc = 0;
    riseData = '0;
    riseErr = 1'b0;
    stable = 1'b1;
    forever begin
      @(negedge clk);
      if (mem_we) wCount++;
      if (resp_valid && !prevValid) begin
        riseCyc  = cyc;
        riseData = resp_rdata;
        riseErr  = resp_err;
        stable   = 1'b1;
      end else if (resp_valid && (resp_rdata !== riseData || resp_err !== riseErr || req_ready))
        stable = 1'b0;
      if (resp_valid && resp_ready) begin
        if (expQ.size() == 0)
          checkOutput("unexpected_resp", 32'd1, 32'd0);
        else begin
          e = expQ.pop_front();
          checkOutput("resp_err", 32'(resp_err), 32'(e.err));
          checkOutput("resp_rdata", resp_rdata, e.rdata);
          checkOutput("resp_latency", 32'(riseCyc), 32'(e.riseCyc));
          checkOutput("write_count", 32'(wCount - e.wBase), 32'(e.writes));
          checkOutput("resp_stable", 32'(stable), 32'd1);
        end
      end
      prevValid = resp_valid;
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    logic        st;
    logic [1:0]  sz;
    logic [31:0] ad;
    int          r;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_resp_rdata", resp_rdata, 32'h0);
    checkOutput("reset_resp_err", 32'(resp_err), 32'd0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset_mem_a", mem_a, 32'h0);
    checkOutput("reset_mem_wd", mem_wd, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < MEM_WORDS; i++) preload(i, $urandom());

    preload(3, 32'h8081_F2F3);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h0D, 32'h0, 0);
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h0E, 32'h0, 5);
    preload(3, 32'h1122_3344);
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h0E, 32'h0000_ABCD, 0);
    checkOutput("halfword_store_mem", dmem[3], 32'hABCD_3344);
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, 0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 0);
    applyStimulus(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0);
    applyStimulus(1'b1, 2'd0, 1'b0, 32'hFF, 32'h1234_5677, 0);
    applyStimulus(1'b0, 2'd1, 1'b1, 32'hFE, 32'h0, 0);

    for (int n = 0; n < 150; n++) begin
      st = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 15));
      sz = (r == 0) ? 2'd3 : 2'(r % 3);
      case ($urandom_range(0, 9))
        0:       ad = $urandom_range(256, 300);
        1:       ad = $urandom();
        default: ad = $urandom_range(0, 255);
      endcase
      applyStimulus(st, sz, 1'($urandom_range(0, 1)), ad, $urandom(), (n % 25 == 0) ? 3 : 0);
    end

    resetDuringWrite();

    repeat (4) @(posedge clk);
    #1;
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    for (int i = 0; i < MEM_WORDS; i++) checkOutput("mem_word", dmem[i], refMem[i]);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: MEM_WORDS, 64, number of 32-bit data-memory words; byte addresses >= 4*MEM_WORDS are out of range.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on posedge clk only.
REQ-004 req_valid  input  1  core request present.
REQ-005 req_ready  output  1  block can accept a request (high only in IDLE).
REQ-006 req_store  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 req_signed  input  1  load sign-extends when 1, zero-extends when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned (bits [7:0] for byte, [15:0] for halfword).
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  core accepts response.
REQ-013 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 resp_err  output  1  request rejected with no memory access.
REQ-015 mem_we  output  1  data-memory write enable.
REQ-016 mem_a  output  32  data-memory byte address, bits [1:0] always 00.
REQ-017 mem_wd  output  32  data-memory write data.
REQ-018 mem_rd  input  32  data-memory read data, combinational from mem_a.

Function
REQ-019 FSM states: IDLE, RD, WR, RESP; one request in flight at a time.
REQ-020 IDLE: on req_valid, latch all req_* fields; error request -> RESP; load or byte/halfword store -> RD; word store -> WR.
REQ-021 Error request: req_size = 11, out-of-range address, or (macro on) misaligned address.
REQ-022 RD: mem_a = {addr[31:2],2'b00}; register mem_rd on the exiting edge; load -> RESP; sub-word store -> WR.
REQ-023 Load extraction: byte lane addr[1:0], halfword lane addr[1]; extension per req_signed; word loads pass through unchanged.
REQ-024 WR: mem_we = 1; mem_wd = registered word with the addressed byte/halfword lanes replaced by req_wdata (full req_wdata for word stores); next state RESP.
REQ-025 RESP: resp_valid = 1 with stable resp_rdata/resp_err; return to IDLE on the edge where resp_ready = 1; hold otherwise.
REQ-026 Latency from the accept edge N: error -> resp_valid at N+1; load or word store -> N+2; sub-word store -> N+3.
REQ-027 Outside RD/WR: mem_a = 0 and mem_wd = 0; mem_we = 0 in every state other than WR.
REQ-028 mem_we = (state == WR) AND reset, so no write occurs on an edge where reset is low.
REQ-029 req_valid during RD/WR/RESP is ignored; no back-to-back accept occurs before the RESP handshake.

Reset
REQ-030 When reset = 0 on posedge clk: state -> IDLE, latched fields and data register cleared, any in-flight request discarded with no response.
REQ-031 Output values while in reset: req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_we 0, mem_a 0, mem_wd 0.

Configuration
REQ-032 LSU_MISALIGN_TRAP_EN defined: a halfword with addr[0] = 1 or a word with addr[1:0] != 00 returns resp_err = 1 with no memory access.
REQ-033 LSU_MISALIGN_TRAP_EN undefined: no misalignment check; the address is truncated to size alignment (halfword clears addr[0], word clears addr[1:0]); size-11 and range errors still apply.

Verification
REQ-034 Preset word 3 = 0x8081_F2F3; load byte signed at addr 0x0D -> resp_rdata 0xFFFF_FFF2 at N+2, resp_err 0.
REQ-035 Store halfword 0xABCD at addr 0x0E over word 3 = 0x1122_3344 -> one mem_we pulse at N+2 with mem_wd 0xABCD_3344; response at N+3.
REQ-036 Store word 0xDEAD_BEEF at addr 0x100 (MEM_WORDS = 64) -> resp_err 1 at N+1, mem_we never asserted.
REQ-037 Load word at addr 0x06 -> macro on: resp_err 1 at N+1; macro off: word 1 is read, resp_err 0.
REQ-038 Hold resp_ready = 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready 0; release -> IDLE on the next edge.
REQ-039 Drive reset = 0 during the WR cycle of a sub-word store -> memory unchanged, outputs as in REQ-031 on the next cycle, no response issued.
